// File: rtl/msft_dv_ip_mmcm_rst_seq.sv
// MMCM reset sequencer: debounces the reset button, pulses the MMCM
// reset, waits for a stable lock with bounded retries, then releases
// the system reset.
//
// Ports:
//   board_clk_i   raw board clock; every flop runs on it
//   RESETn_i      async active-low power-on reset
//   btn_rst_ni    async active-low, bouncy user reset button
//   mmcm_locked_i MMCM lock, async to board_clk_i
//   mmcm_rstn_o   MMCM reset, 0 = held in reset
//   sys_rstn_o    registered active-low system reset
//   lock_fail_o   sticky: every lock attempt timed out
//   retry_cnt_o   retries used in the current startup sequence
//   state_o       FSM state, for debug
module msft_dv_ip_mmcm_rst_seq #(
  parameter int DebounceCycles    = 1000,
  parameter int MmcmRstCycles     = 16,
  parameter int LockTimeoutCycles = 100000,
  parameter int LockStableCycles  = 64,
  parameter int RelDelayCycles    = 256,
  parameter int MaxRetries        = 3,
  parameter int RetryW            =
    (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1
) (
  input  logic              board_clk_i,
  input  logic              RESETn_i,
  input  logic              btn_rst_ni,
  input  logic              mmcm_locked_i,
  output logic              mmcm_rstn_o,
  output logic              sys_rstn_o,
  output logic              lock_fail_o,
  output logic [RetryW-1:0] retry_cnt_o,
  output logic [2:0]        state_o
);

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MaxCnt =
    max2(max2(MmcmRstCycles, LockTimeoutCycles),
         max2(LockStableCycles, RelDelayCycles));
  localparam int CntW = $clog2(MaxCnt + 1);
  localparam int DbW  = $clog2(DebounceCycles + 1);

  localparam logic [CntW-1:0] RstLast =
    CntW'(MmcmRstCycles - 1);
  localparam logic [CntW-1:0] ToLast =
    CntW'(LockTimeoutCycles - 1);
  // The WAIT_LOCK sample that caused entry is the
  // first of the consecutive locked cycles.
  localparam logic [CntW-1:0] StableLast =
    CntW'((LockStableCycles > 1) ? LockStableCycles - 2 : 0);
  // REL_DELAY lasts RelDelayCycles+1 cycles.
  localparam logic [CntW-1:0] RelLast =
    CntW'(RelDelayCycles);
  localparam logic [DbW-1:0] DbLast =
    DbW'(DebounceCycles - 1);
  localparam logic [RetryW-1:0] RetryMax =
    RetryW'(MaxRetries);

  typedef enum logic [2:0] {
    RST_MMCM  = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    REL_DELAY = 3'd3,
    RUN       = 3'd4,
    FAIL      = 3'd5
  } state_t;

  state_t            state, state_n;
  logic [CntW-1:0]   cnt, cnt_n;
  logic [RetryW-1:0] retry, retry_n;

  logic           btn_m, btn_s;
  logic           lock_m, lock_s;
  logic           btn_db, btn_db_d;
  logic [DbW-1:0] db_cnt;
  logic           press;

  // Button synchroniser resets to "released" so that
  // leaving reset never looks like a press.
  always_ff @(posedge board_clk_i or negedge RESETn_i) begin
    if (!RESETn_i) begin
      btn_m    <= 1'b1;
      btn_s    <= 1'b1;
      lock_m   <= 1'b0;
      lock_s   <= 1'b0;
      btn_db   <= 1'b1;
      btn_db_d <= 1'b1;
      db_cnt   <= '0;
    end else begin
      btn_m    <= btn_rst_ni;
      btn_s    <= btn_m;
      lock_m   <= mmcm_locked_i;
      lock_s   <= lock_m;
      btn_db_d <= btn_db;
      if (btn_s != btn_db) begin
        if (db_cnt == DbLast) begin
          btn_db <= btn_s;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign press = btn_db_d & ~btn_db;

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    retry_n = retry;
    if (press) begin
      state_n = RST_MMCM;
      retry_n = '0;
      cnt_n   = '0;
    end else begin
      unique case (state)
        RST_MMCM: begin
          if (!btn_db) begin
            cnt_n = '0;
          end else if (cnt == RstLast) begin
            state_n = WAIT_LOCK;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_n = STABLE;
          end else if (cnt == ToLast) begin
            if (retry == RetryMax) begin
              state_n = FAIL;
            end else begin
              retry_n = retry + 1'b1;
              state_n = RST_MMCM;
            end
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_n = WAIT_LOCK;
          end else if (cnt == StableLast) begin
            state_n = REL_DELAY;
          end
        end
        REL_DELAY: begin
          if (!lock_s) begin
            state_n = WAIT_LOCK;
          end else if (cnt == RelLast) begin
            state_n = RUN;
          end
        end
        RUN: begin
          cnt_n = cnt;
          // Lock loss in service is not a startup retry.
          if (!lock_s) begin
            state_n = RST_MMCM;
            retry_n = '0;
          end
        end
        FAIL: begin
          cnt_n = cnt;
        end
        default: begin
          state_n = RST_MMCM;
        end
      endcase
    end
    if (state_n != state) begin
      cnt_n = '0;
    end
  end

  // Outputs are decoded from the next state so they
  // change on the same edge the FSM enters a state.
  always_ff @(posedge board_clk_i or negedge RESETn_i) begin
    if (!RESETn_i) begin
      state       <= RST_MMCM;
      cnt         <= '0;
      retry       <= '0;
      mmcm_rstn_o <= 1'b0;
      sys_rstn_o  <= 1'b0;
      lock_fail_o <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      retry       <= retry_n;
      mmcm_rstn_o <= (state_n != RST_MMCM);
      sys_rstn_o  <= (state_n == RUN);
      lock_fail_o <= (state_n == FAIL);
    end
  end

  assign retry_cnt_o = retry;
  assign state_o     = state;

endmodule

// File: tb/tb_msft_dv_ip_mmcm_rst_seq.sv
// Directed bench for msft_dv_ip_mmcm_rst_seq.
// Edge names (E/A/B/F) count posedges from a marked point.
module tb_msft_dv_ip_mmcm_rst_seq;

  logic       clk;
  logic       rstn;
  logic       btn;
  logic       locked;
  logic       mmcm_rstn;
  logic       sys_rstn;
  logic       lock_fail;
  logic [1:0] retry;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  msft_dv_ip_mmcm_rst_seq #(
    .DebounceCycles   (4),
    .MmcmRstCycles    (4),
    .LockTimeoutCycles(32),
    .LockStableCycles (8),
    .RelDelayCycles   (16),
    .MaxRetries       (2)
  ) dut (
    .board_clk_i  (clk),
    .RESETn_i     (rstn),
    .btn_rst_ni   (btn),
    .mmcm_locked_i(locked),
    .mmcm_rstn_o  (mmcm_rstn),
    .sys_rstn_o   (sys_rstn),
    .lock_fail_o  (lock_fail),
    .retry_cnt_o  (retry),
    .state_o      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_mmcm"}, 32'(mmcm_rstn), 0);
    chk({tag, "_sys"}, 32'(sys_rstn), 0);
    chk({tag, "_fail"}, 32'(lock_fail), 0);
    chk({tag, "_retry"}, 32'(retry), 0);
    chk({tag, "_state"}, 32'(state), 0);
  endtask

  initial begin
    rstn   = 1'b0;
    btn    = 1'b1;
    locked = 1'b0;
    step(2);
    chk_rst("reset");

    // 1: clean boot, lock rises at E10
    rstn = 1'b1;
    step(3);
    chk("t1_pulse_e3", 32'(mmcm_rstn), 0);
    step(1);
    chk("t1_wait_e4", 32'(state), 1);
    chk("t1_mmcm_e4", 32'(mmcm_rstn), 1);
    step(6);
    locked = 1'b1;
    step(2);
    chk("t1_wait_e12", 32'(state), 1);
    step(1);
    chk("t1_stable_e13", 32'(state), 2);
    step(6);
    chk("t1_stable_e19", 32'(state), 2);
    step(1);
    chk("t1_rel_e20", 32'(state), 3);
    step(16);
    chk("t1_sys_e36", 32'(sys_rstn), 0);
    step(1);
    chk("t1_sys_e37", 32'(sys_rstn), 1);
    chk("t1_run_e37", 32'(state), 4);
    chk("t1_retry", 32'(retry), 0);

    // 4: one-cycle lock drop in RUN
    step(5);
    locked = 1'b0;
    step(1);
    locked = 1'b1;
    step(1);
    chk("t4_sys_a2", 32'(sys_rstn), 1);
    step(1);
    chk("t4_sys_a3", 32'(sys_rstn), 0);
    chk("t4_state_a3", 32'(state), 0);
    chk("t4_mmcm_a3", 32'(mmcm_rstn), 0);
    chk("t4_retry_a3", 32'(retry), 0);
    step(3);
    chk("t4_mmcm_a6", 32'(mmcm_rstn), 0);
    step(1);
    chk("t4_mmcm_a7", 32'(mmcm_rstn), 1);
    chk("t4_wait_a7", 32'(state), 1);
    step(1);
    chk("t4_stable_a8", 32'(state), 2);
    step(23);
    chk("t4_sys_a31", 32'(sys_rstn), 0);
    step(1);
    chk("t4_sys_a32", 32'(sys_rstn), 1);

    // 5: bouncy button, stable low from B3
    step(3);
    btn = 1'b0;
    step(2);
    btn = 1'b1;
    step(1);
    btn = 1'b0;
    step(6);
    chk("t5_run_b9", 32'(state), 4);
    chk("t5_sys_b9", 32'(sys_rstn), 1);
    step(1);
    chk("t5_rst_b10", 32'(state), 0);
    chk("t5_sys_b10", 32'(sys_rstn), 0);
    chk("t5_mmcm_b10", 32'(mmcm_rstn), 0);
    step(5);
    chk("t5_hold_b15", 32'(state), 0);
    btn = 1'b1;
    step(9);
    chk("t5_hold_b24", 32'(state), 0);
    chk("t5_mmcm_b24", 32'(mmcm_rstn), 0);
    step(1);
    chk("t5_wait_b25", 32'(state), 1);
    chk("t5_mmcm_b25", 32'(mmcm_rstn), 1);
    step(24);
    chk("t5_sys_b49", 32'(sys_rstn), 0);
    step(1);
    chk("t5_sys_b50", 32'(sys_rstn), 1);

    // 2: lock never asserts
    locked = 1'b0;
    rstn   = 1'b0;
    #1;
    chk_rst("t2_async");
    step(1);
    rstn = 1'b1;
    step(4);
    chk("t2_wait_e4", 32'(state), 1);
    step(31);
    chk("t2_wait_e35", 32'(state), 1);
    chk("t2_retry_e35", 32'(retry), 0);
    step(1);
    chk("t2_rst_e36", 32'(state), 0);
    chk("t2_mmcm_e36", 32'(mmcm_rstn), 0);
    chk("t2_retry_e36", 32'(retry), 1);
    step(3);
    chk("t2_mmcm_e39", 32'(mmcm_rstn), 0);
    step(1);
    chk("t2_mmcm_e40", 32'(mmcm_rstn), 1);
    step(32);
    chk("t2_rst_e72", 32'(state), 0);
    chk("t2_retry_e72", 32'(retry), 2);
    step(35);
    chk("t2_wait_e107", 32'(state), 1);
    step(1);
    chk("t2_fail_e108", 32'(state), 5);
    chk("t2_lf_e108", 32'(lock_fail), 1);
    chk("t2_mmcm_e108", 32'(mmcm_rstn), 1);
    chk("t2_sys_e108", 32'(sys_rstn), 0);
    chk("t2_retry_e108", 32'(retry), 2);
    step(20);
    chk("t2_fail_held", 32'(state), 5);

    // button press leaves FAIL
    btn = 1'b0;
    step(6);
    chk("fp_fail_f6", 32'(state), 5);
    step(1);
    chk("fp_rst_f7", 32'(state), 0);
    chk("fp_lf_f7", 32'(lock_fail), 0);
    chk("fp_retry_f7", 32'(retry), 0);
    step(1);
    btn = 1'b1;

    // 3: lock chatters high 5 / low 1
    for (int p = 0; p < 10; p++) begin
      locked = 1'b1;
      for (int c = 0; c < 6; c++) begin
        if (c == 5) locked = 1'b0;
        step(1);
        chk("t3_no_rel", 32'(state != 3'd3), 1);
        chk("t3_sys", 32'(sys_rstn), 0);
      end
    end
    for (int i = 0; i < 80; i++) begin
      if (retry == 2'd1) break;
      step(1);
    end
    chk("t3_retry", 32'(retry), 1);

    // 6: reset in the middle of REL_DELAY
    locked = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (state == 3'd3) break;
      step(1);
    end
    chk("t6_rel", 32'(state), 3);
    step(4);
    chk("t6_rel_mid", 32'(state), 3);
    #3;
    rstn = 1'b0;
    #1;
    chk_rst("t6_async");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    step(4);
    chk("t6_wait_e4", 32'(state), 1);
    step(1);
    chk("t6_stable_e5", 32'(state), 2);
    step(7);
    chk("t6_rel_e12", 32'(state), 3);
    step(16);
    chk("t6_sys_e28", 32'(sys_rstn), 0);
    step(1);
    chk("t6_sys_e29", 32'(sys_rstn), 1);
    chk("t6_run_e29", 32'(state), 4);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
